// File: rtl/aq_ifu_ras_ctrl_pkg.sv
// Shared IFU return-address-stack constants and the wrapping pointer step
// used by the RAS pointer logic.
package aq_ifu_ras_ctrl_pkg;

  localparam int RAS_DEPTH    = 6;
  localparam int RAS_PC_WIDTH = 24;
  localparam int RAS_PTR_W    = 3;

  // Next or previous slot in a ring of 'depth' entries.
  function automatic int unsigned ras_ptr_wrap(
    input int unsigned ptr,
    input logic        up,
    input int unsigned depth
  );
    int unsigned res;
    if (up) begin
      res = (ptr >= depth - 1) ? 0 : ptr + 1;
    end else begin
      res = (ptr == 0) ? depth - 1 : ptr - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/aq_ifu_ras_ctrl_if.sv
// Signal bundle between the IFU prediction logic / RAS entry registers and
// the RAS controller.
interface aq_ifu_ras_ctrl_if
  import aq_ifu_ras_ctrl_pkg::*;
#(
  parameter int DEPTH    = RAS_DEPTH,
  parameter int PC_WIDTH = RAS_PC_WIDTH,
  parameter int PTR_W    = RAS_PTR_W
);

  // push/pop/flush/rcv are single-cycle valid strobes with no ready: the
  // controller accepts every strobe in the cycle it is high, resolving
  // conflicts as flush > recover > push/pop.
  logic                      ras_push_vld;
  logic [PC_WIDTH-1:0]       ras_push_pc;
  logic                      ras_pop_vld;
  logic                      ras_flush;
  logic                      ras_rcv_vld;
  logic [PTR_W-1:0]          ras_rcv_ptr;
  logic [PTR_W-1:0]          ras_rcv_cnt;
  logic [DEPTH*PC_WIDTH-1:0] ras_entry_pc_flat;

  logic [DEPTH-1:0]          ras_entry_upd;
  logic [PC_WIDTH-1:0]       ras_upd_pc;
  logic [PC_WIDTH-1:0]       ras_top_pc;
  logic                      ras_top_vld;
  logic [PTR_W-1:0]          ras_cur_ptr;
  logic [PTR_W-1:0]          ras_cur_cnt;
  logic                      ras_full;

  modport master (
    output ras_push_vld, ras_push_pc, ras_pop_vld, ras_flush,
           ras_rcv_vld, ras_rcv_ptr, ras_rcv_cnt, ras_entry_pc_flat,
    input  ras_entry_upd, ras_upd_pc, ras_top_pc, ras_top_vld,
           ras_cur_ptr, ras_cur_cnt, ras_full
  );

  modport slave (
    input  ras_push_vld, ras_push_pc, ras_pop_vld, ras_flush,
           ras_rcv_vld, ras_rcv_ptr, ras_rcv_cnt, ras_entry_pc_flat,
    output ras_entry_upd, ras_upd_pc, ras_top_pc, ras_top_vld,
           ras_cur_ptr, ras_cur_cnt, ras_full
  );

endinterface

// File: rtl/aq_ifu_ras_ptr.sv
// RAS write pointer and valid count: flush / recover / push / pop
// next-state logic and the derived top-of-stack index.
module aq_ifu_ras_ptr
  import aq_ifu_ras_ctrl_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = RAS_PTR_W
) (
  input  logic             entry_clk,
  input  logic             cpurst_b,
  input  logic             flush,
  input  logic             rcv_vld,
  input  logic [PTR_W-1:0] rcv_ptr,
  input  logic [PTR_W-1:0] rcv_cnt,
  input  logic             push_vld,
  input  logic             pop_vld,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] cnt,
  output logic [PTR_W-1:0] top_idx
);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] cnt_nxt;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             stack_empty;

  assign ptr_inc     = PTR_W'(ras_ptr_wrap(32'(ptr), 1'b1, DEPTH));
  assign ptr_dec     = PTR_W'(ras_ptr_wrap(32'(ptr), 1'b0, DEPTH));
  assign stack_empty = (cnt == '0);
  assign top_idx     = ptr_dec;

  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (flush) begin
      ptr_nxt = '0;
      cnt_nxt = '0;
    end else if (rcv_vld) begin
      // An out-of-range checkpoint pointer cannot come from a legal
      // checkpoint; fall back to slot 0 rather than index past the ring.
      ptr_nxt = (rcv_ptr >= DEPTH_P) ? '0 : rcv_ptr;
      cnt_nxt = (rcv_cnt > DEPTH_P) ? DEPTH_P : rcv_cnt;
    end else if (push_vld && (!pop_vld || stack_empty)) begin
      ptr_nxt = ptr_inc;
      cnt_nxt = (cnt == DEPTH_P) ? cnt : cnt + PTR_W'(1);
    end else if (pop_vld && !push_vld && !stack_empty) begin
      ptr_nxt = ptr_dec;
      cnt_nxt = cnt - PTR_W'(1);
    end
  end

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/aq_ifu_ras_ctrl.sv
// IFU return-address-stack controller: decodes call/return predictions into
// one-hot entry write strobes and selects the top-of-stack return target.
module aq_ifu_ras_ctrl
  import aq_ifu_ras_ctrl_pkg::*;
#(
  parameter int DEPTH    = RAS_DEPTH,
  parameter int PC_WIDTH = RAS_PC_WIDTH,
  parameter int PTR_W    = RAS_PTR_W
) (
  input  logic             entry_clk,
  input  logic             cpurst_b,
  aq_ifu_ras_ctrl_if.slave ras_if
);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cnt;
  logic [PTR_W-1:0] top_idx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  aq_ifu_ras_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ras_ptr (
    .entry_clk (entry_clk),
    .cpurst_b  (cpurst_b),
    .flush     (ras_if.ras_flush),
    .rcv_vld   (ras_if.ras_rcv_vld),
    .rcv_ptr   (ras_if.ras_rcv_ptr),
    .rcv_cnt   (ras_if.ras_rcv_cnt),
    .push_vld  (ras_if.ras_push_vld),
    .pop_vld   (ras_if.ras_pop_vld),
    .ptr       (ptr),
    .cnt       (cnt),
    .top_idx   (top_idx)
  );

  // A push that coincides with a pop on a non-empty stack replaces the top
  // entry in place; otherwise a push writes the next free slot.
  assign wr_en  = ras_if.ras_push_vld && !ras_if.ras_flush && !ras_if.ras_rcv_vld;
  assign wr_idx = (ras_if.ras_pop_vld && (cnt != '0)) ? top_idx : ptr;

  always_comb begin
    ras_if.ras_entry_upd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ras_if.ras_entry_upd[i] = wr_en && (wr_idx == PTR_W'(i));
    end
  end

  always_comb begin
    ras_if.ras_top_pc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == PTR_W'(i)) begin
        ras_if.ras_top_pc = ras_if.ras_entry_pc_flat[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  assign ras_if.ras_upd_pc  = ras_if.ras_push_pc;
  assign ras_if.ras_top_vld = (cnt != '0);
  assign ras_if.ras_full    = (cnt == DEPTH_P);
  assign ras_if.ras_cur_ptr = ptr;
  assign ras_if.ras_cur_cnt = cnt;

endmodule

// File: tb/tb_aq_ifu_ras_ctrl.sv
// Bench for aq_ifu_ras_ctrl: external entry registers, a ring/count model of
// the stack, directed scenarios and a randomized phase.
module tb_aq_ifu_ras_ctrl;
  import aq_ifu_ras_ctrl_pkg::*;

  localparam int D  = RAS_DEPTH;
  localparam int W  = RAS_PC_WIDTH;
  localparam int PW = RAS_PTR_W;

  logic entry_clk;
  logic cpurst_b;

  aq_ifu_ras_ctrl_if #(.DEPTH(D), .PC_WIDTH(W), .PTR_W(PW)) rif ();

  aq_ifu_ras_ctrl #(.DEPTH(D), .PC_WIDTH(W), .PTR_W(PW)) dut (
    .entry_clk (entry_clk),
    .cpurst_b  (cpurst_b),
    .ras_if    (rif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    entry_clk = 1'b0;
    forever #5 entry_clk = ~entry_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- entry registers living outside the block ----------------
  logic [W-1:0] ent [D];

  always @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < D; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++) if (rif.ras_entry_upd[i]) ent[i] <= rif.ras_upd_pc;
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_flat
    assign rif.ras_entry_pc_flat[g*W +: W] = ent[g];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int           m_ptr, m_cnt;
  logic [W-1:0] m_mem [D];

  always @(negedge entry_clk) begin
    int wi, np, nc, rp, rc;
    logic [D-1:0] e_upd;
    if (!cpurst_b) begin
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      chk("rst_ptr", 32'(rif.ras_cur_ptr), 0);
      chk("rst_cnt", 32'(rif.ras_cur_cnt), 0);
      chk("rst_top_vld", 32'(rif.ras_top_vld), 0);
      chk("rst_full", 32'(rif.ras_full), 0);
    end else begin
      wi = -1;
      np = m_ptr;
      nc = m_cnt;
      rp = int'(rif.ras_rcv_ptr);
      rc = int'(rif.ras_rcv_cnt);
      if (rif.ras_flush) begin
        np = 0;
        nc = 0;
      end else if (rif.ras_rcv_vld) begin
        np = (rp >= D) ? 0 : rp;
        nc = (rc > D) ? D : rc;
      end else if (rif.ras_push_vld && rif.ras_pop_vld && m_cnt > 0) begin
        wi = (m_ptr + D - 1) % D;
      end else if (rif.ras_push_vld) begin
        wi = m_ptr;
        np = (m_ptr + 1) % D;
        nc = (m_cnt + 1 > D) ? D : m_cnt + 1;
      end else if (rif.ras_pop_vld && m_cnt > 0) begin
        np = (m_ptr + D - 1) % D;
        nc = m_cnt - 1;
      end
      e_upd = '0;
      if (wi >= 0) e_upd[wi] = 1'b1;

      chk("cmp_upd", 32'(rif.ras_entry_upd), 32'(e_upd));
      chk("cmp_upd_pc", 32'(rif.ras_upd_pc), 32'(rif.ras_push_pc));
      chk("cmp_top_pc", 32'(rif.ras_top_pc), 32'(m_mem[(m_ptr + D - 1) % D]));
      chk("cmp_top_vld", 32'(rif.ras_top_vld), 32'(m_cnt != 0));
      chk("cmp_ptr", 32'(rif.ras_cur_ptr), 32'(m_ptr));
      chk("cmp_cnt", 32'(rif.ras_cur_cnt), 32'(m_cnt));
      chk("cmp_full", 32'(rif.ras_full), 32'(m_cnt == D));

      if (wi >= 0) m_mem[wi] = rif.ras_push_pc;
      m_ptr = np;
      m_cnt = nc;
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs just after the edge and returns at the
  // following negedge, where that cycle's combinational outputs are stable.
  task automatic cyc(input logic push, input logic [W-1:0] pc, input logic pop,
                     input logic fl, input logic rv, input logic [PW-1:0] rp,
                     input logic [PW-1:0] rc);
    @(posedge entry_clk);
    #1;
    rif.ras_push_vld = push;
    rif.ras_push_pc  = pc;
    rif.ras_pop_vld  = pop;
    rif.ras_flush    = fl;
    rif.ras_rcv_vld  = rv;
    rif.ras_rcv_ptr  = rp;
    rif.ras_rcv_cnt  = rc;
    @(negedge entry_clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push(input logic [W-1:0] pc);
    cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic flush();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] exp_q[$];

  initial begin
    rif.ras_push_vld = 1'b0;
    rif.ras_push_pc  = '0;
    rif.ras_pop_vld  = 1'b0;
    rif.ras_flush    = 1'b0;
    rif.ras_rcv_vld  = 1'b0;
    rif.ras_rcv_ptr  = '0;
    rif.ras_rcv_cnt  = '0;
    cpurst_b = 1'b1;
    #1 cpurst_b = 1'b0;
    repeat (3) @(posedge entry_clk);
    #2 cpurst_b = 1'b1;

    // Three consecutive pushes after reset
    push(24'h000100);
    chk("t1_reset_ptr", 32'(rif.ras_cur_ptr), 0);
    chk("t1_reset_cnt", 32'(rif.ras_cur_cnt), 0);
    chk("t1_reset_full", 32'(rif.ras_full), 0);
    chk("t1_upd0", 32'(rif.ras_entry_upd), 32'h01);
    push(24'h000200);
    chk("t1_upd1", 32'(rif.ras_entry_upd), 32'h02);
    push(24'h000300);
    chk("t1_upd2", 32'(rif.ras_entry_upd), 32'h04);
    idle();
    chk("t1_top_pc", 32'(rif.ras_top_pc), 32'h300);
    chk("t1_cnt", 32'(rif.ras_cur_cnt), 3);
    chk("t1_ptr", 32'(rif.ras_cur_ptr), 3);
    chk("t1_top_vld", 32'(rif.ras_top_vld), 1);

    // Overflow then drain, plus underflow
    flush();
    for (int k = 1; k <= 7; k++) begin
      push(W'(k * 16));
      if (k == 7) begin
        chk("t2_full", 32'(rif.ras_full), 1);
        chk("t2_wrap_upd", 32'(rif.ras_entry_upd), 32'h01);
      end
    end
    for (int k = 7; k >= 2; k--) exp_q.push_back(W'(k * 16));
    for (int k = 0; k < 6; k++) begin
      pop();
      if (k == 0) chk("t2_wrap_ptr", 32'(rif.ras_cur_ptr), 1);
      chk("t2_pop_pc", 32'(rif.ras_top_pc), 32'(exp_q.pop_front()));
    end
    idle();
    chk("t2_empty_vld", 32'(rif.ras_top_vld), 0);
    chk("t2_empty_ptr", 32'(rif.ras_cur_ptr), 1);
    pop();
    idle();
    chk("t2_uflow_ptr", 32'(rif.ras_cur_ptr), 1);
    chk("t2_uflow_cnt", 32'(rif.ras_cur_cnt), 0);

    // Simultaneous push + pop replaces the top
    flush();
    push(24'h0000A0);
    push(24'h0000B0);
    cyc(1'b1, 24'h0000C0, 1'b1, 1'b0, 1'b0, '0, '0);
    chk("t3_upd", 32'(rif.ras_entry_upd), 32'h02);
    chk("t3_upd_pc", 32'(rif.ras_upd_pc), 32'hC0);
    idle();
    chk("t3_cnt", 32'(rif.ras_cur_cnt), 2);
    chk("t3_top_pc", 32'(rif.ras_top_pc), 32'hC0);

    // Checkpoint and recovery
    flush();
    push(24'h000011);
    push(24'h000022);
    idle();
    chk("t4_ckpt_ptr", 32'(rif.ras_cur_ptr), 2);
    chk("t4_ckpt_cnt", 32'(rif.ras_cur_cnt), 2);
    push(24'h000033);
    push(24'h000044);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2);
    chk("t4_rcv_upd", 32'(rif.ras_entry_upd), 0);
    idle();
    chk("t4_ptr", 32'(rif.ras_cur_ptr), 2);
    chk("t4_cnt", 32'(rif.ras_cur_cnt), 2);
    chk("t4_top_pc", 32'(rif.ras_top_pc), 32'h22);

    // Flush wins over recover and push
    flush();
    for (int k = 1; k <= 4; k++) push(W'(k));
    cyc(1'b1, 24'h000077, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3);
    chk("t5_upd", 32'(rif.ras_entry_upd), 0);
    idle();
    chk("t5_ptr", 32'(rif.ras_cur_ptr), 0);
    chk("t5_cnt", 32'(rif.ras_cur_cnt), 0);
    chk("t5_top_vld", 32'(rif.ras_top_vld), 0);

    // Asynchronous reset in the middle of a push
    flush();
    push(24'h000001);
    push(24'h000002);
    push(24'h000003);
    @(posedge entry_clk);
    #1;
    rif.ras_push_vld = 1'b1;
    rif.ras_push_pc  = 24'h000099;
    #2 cpurst_b = 1'b0;
    #1;
    chk("t6_ptr", 32'(rif.ras_cur_ptr), 0);
    chk("t6_cnt", 32'(rif.ras_cur_cnt), 0);
    chk("t6_top_vld", 32'(rif.ras_top_vld), 0);
    chk("t6_full", 32'(rif.ras_full), 0);
    rif.ras_push_vld = 1'b0;
    @(posedge entry_clk);
    #2 cpurst_b = 1'b1;
    push(24'h000055);
    chk("t6_upd", 32'(rif.ras_entry_upd), 32'h01);
    idle();
    chk("t6_top_pc", 32'(rif.ras_top_pc), 32'h55);

    // Randomized phase: push-heavy and pop-heavy stretches
    for (int n = 0; n < 3000; n++) begin
      int r, push_pct;
      logic p, q, f, v;
      push_pct = ((n / 100) % 2 == 0) ? 70 : 30;
      r = $urandom_range(0, 99);
      f = (r < 2);
      v = (r >= 2 && r < 6);
      p = ($urandom_range(0, 99) < push_pct);
      q = ($urandom_range(0, 99) < (100 - push_pct));
      cyc(p, W'($urandom), q, f, v, PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7)));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
